// File: rtl/frogger_pkg.sv
// Shared definitions for the Frogger goal-row logic.
//   - DATAWIDTH default for the entry/pattern buses
//   - goal-row wall pattern at level start (1 = wall, 0 = open home slot)
//   - column indices of the two home slots
//   - entry-manager state encoding (3 bits)
package frogger_pkg;

  localparam int          FROG_DATAWIDTH    = 8;
  localparam logic [7:0]  FROG_BASE_PATTERN = 8'b11011011;
  localparam int          FROG_LEFT_BIT     = 5;
  localparam int          FROG_RIGHT_BIT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LOSE    = 3'd2,
    ST_FILL_L  = 3'd3,
    ST_FILL_R  = 3'd4,
    ST_WIN     = 3'd5,
    ST_RELEASE = 3'd6
  } entry_state_e;

endpackage

// File: rtl/sc_entry_manager.sv
// Goal-row (entry) manager for the Frogger board.
// Drives the entry bus into the entry comparator while the frog sits in the
// goal row, consumes the comparator's active-low verdicts, marks filled home
// slots, and issues respawn / lose / win pulses.
//
// Ports:
//   SC_ENTRYMANAGER_CLOCK_50          system clock
//   SC_ENTRYMANAGER_RESET_InLow       asynchronous active-low reset
//   SC_ENTRYMANAGER_clear_InLow       synchronous new-game clear, active-low
//   SC_ENTRYMANAGER_frogAtTop_InLow   low while the frog occupies the goal row
//   SC_ENTRYMANAGER_lose_InLow        comparator: frog hit a wall
//   SC_ENTRYMANAGER_enterLeft_InLow   comparator: frog on left home slot
//   SC_ENTRYMANAGER_enterRight_InLow  comparator: frog on right home slot
//   SC_ENTRYMANAGER_entryBUS_Out      pattern to comparator, 0 = comparator idle
//   SC_ENTRYMANAGER_goalRow_Out       current goal-row pattern, for display
//   SC_ENTRYMANAGER_filled_Out        number of filled home slots (0..2)
//   SC_ENTRYMANAGER_respawn_OutLow    one-cycle respawn request
//   SC_ENTRYMANAGER_lose_OutLow       one-cycle life-lost pulse
//   SC_ENTRYMANAGER_win_OutLow        one-cycle level-complete pulse
module sc_entry_manager
  import frogger_pkg::*;
#(
  parameter int                   DATAWIDTH    = FROG_DATAWIDTH,
  parameter logic [DATAWIDTH-1:0] BASE_PATTERN = DATAWIDTH'(FROG_BASE_PATTERN),
  parameter int                   LEFT_BIT     = FROG_LEFT_BIT,
  parameter int                   RIGHT_BIT    = FROG_RIGHT_BIT
) (
  input  logic                 SC_ENTRYMANAGER_CLOCK_50,
  input  logic                 SC_ENTRYMANAGER_RESET_InLow,
  input  logic                 SC_ENTRYMANAGER_clear_InLow,
  input  logic                 SC_ENTRYMANAGER_frogAtTop_InLow,
  input  logic                 SC_ENTRYMANAGER_lose_InLow,
  input  logic                 SC_ENTRYMANAGER_enterLeft_InLow,
  input  logic                 SC_ENTRYMANAGER_enterRight_InLow,
  output logic [DATAWIDTH-1:0] SC_ENTRYMANAGER_entryBUS_Out,
  output logic [DATAWIDTH-1:0] SC_ENTRYMANAGER_goalRow_Out,
  output logic [1:0]           SC_ENTRYMANAGER_filled_Out,
  output logic                 SC_ENTRYMANAGER_respawn_OutLow,
  output logic                 SC_ENTRYMANAGER_lose_OutLow,
  output logic                 SC_ENTRYMANAGER_win_OutLow
);

  entry_state_e         state_q, state_d;
  logic [DATAWIDTH-1:0] pattern_q, pattern_d;
  logic [DATAWIDTH-1:0] entry_bus_q, entry_bus_d;
  logic [1:0]           filled_q, filled_d;
  logic                 respawn_n_q, respawn_n_d;
  logic                 lose_n_q, lose_n_d;
  logic                 win_n_q, win_n_d;

  logic [1:0]           filled_inc;

  // Saturating increment; a third fill cannot happen, but never wrap.
  assign filled_inc = (filled_q == 2'd2) ? 2'd2 : filled_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    filled_d  = filled_q;

    case (state_q)
      ST_IDLE: begin
        if (!SC_ENTRYMANAGER_frogAtTop_InLow) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Pattern and count are updated on entry to FILL_x so the new
        // values are visible in the same cycle as the respawn pulse.
        if (SC_ENTRYMANAGER_frogAtTop_InLow) begin
          state_d = ST_IDLE;
        end else if (!SC_ENTRYMANAGER_lose_InLow) begin
          state_d = ST_LOSE;
        end else if (!SC_ENTRYMANAGER_enterLeft_InLow && !pattern_q[LEFT_BIT]) begin
          state_d             = ST_FILL_L;
          pattern_d[LEFT_BIT] = 1'b1;
          filled_d            = filled_inc;
        end else if (!SC_ENTRYMANAGER_enterRight_InLow && !pattern_q[RIGHT_BIT]) begin
          state_d              = ST_FILL_R;
          pattern_d[RIGHT_BIT] = 1'b1;
          filled_d             = filled_inc;
        end
      end
      ST_LOSE: state_d = ST_RELEASE;
      ST_FILL_L, ST_FILL_R: begin
        state_d = (filled_q == 2'd2) ? ST_WIN : ST_RELEASE;
      end
      ST_WIN: begin
        state_d   = ST_RELEASE;
        pattern_d = BASE_PATTERN;
        filled_d  = 2'd0;
      end
      ST_RELEASE: begin
        // Wait for the frog to leave the row so one visit scores once.
        if (SC_ENTRYMANAGER_frogAtTop_InLow) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!SC_ENTRYMANAGER_clear_InLow) begin
      state_d   = ST_IDLE;
      pattern_d = BASE_PATTERN;
      filled_d  = 2'd0;
    end

    // Outputs are registered copies of what the next state implies.
    entry_bus_d = (state_d == ST_ARM) ? pattern_d : '0;
    respawn_n_d = !((state_d == ST_LOSE) || (state_d == ST_FILL_L) || (state_d == ST_FILL_R));
    lose_n_d    = (state_d != ST_LOSE);
    win_n_d     = (state_d != ST_WIN);
  end

  always_ff @(posedge SC_ENTRYMANAGER_CLOCK_50 or negedge SC_ENTRYMANAGER_RESET_InLow) begin
    if (!SC_ENTRYMANAGER_RESET_InLow) begin
      state_q     <= ST_IDLE;
      pattern_q   <= BASE_PATTERN;
      filled_q    <= 2'd0;
      entry_bus_q <= '0;
      respawn_n_q <= 1'b1;
      lose_n_q    <= 1'b1;
      win_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      filled_q    <= filled_d;
      entry_bus_q <= entry_bus_d;
      respawn_n_q <= respawn_n_d;
      lose_n_q    <= lose_n_d;
      win_n_q     <= win_n_d;
    end
  end

  assign SC_ENTRYMANAGER_entryBUS_Out   = entry_bus_q;
  assign SC_ENTRYMANAGER_goalRow_Out    = pattern_q;
  assign SC_ENTRYMANAGER_filled_Out     = filled_q;
  assign SC_ENTRYMANAGER_respawn_OutLow = respawn_n_q;
  assign SC_ENTRYMANAGER_lose_OutLow    = lose_n_q;
  assign SC_ENTRYMANAGER_win_OutLow     = win_n_q;

endmodule

// File: tb/tb_sc_entry_manager.sv
// Bench for sc_entry_manager: a comparator model closes the loop from the
// entry bus, and a scripted behavioural model predicts every output cycle.
module tb_sc_entry_manager;

  localparam logic [7:0] BASE = 8'hDB;
  localparam logic [7:0] POS_L = 8'h20;
  localparam logic [7:0] POS_R = 8'h04;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr_n = 1'b1;
  logic       at_top_n = 1'b1;
  logic [7:0] frog_pos = 8'h00;
  logic       cmp_lose_n, cmp_l_n, cmp_r_n;
  logic [7:0] bus, goal;
  logic [1:0] filled;
  logic       resp_n, lose_n, win_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sc_entry_manager dut (
    .SC_ENTRYMANAGER_CLOCK_50         (clk),
    .SC_ENTRYMANAGER_RESET_InLow      (rst_n),
    .SC_ENTRYMANAGER_clear_InLow      (clr_n),
    .SC_ENTRYMANAGER_frogAtTop_InLow  (at_top_n),
    .SC_ENTRYMANAGER_lose_InLow       (cmp_lose_n),
    .SC_ENTRYMANAGER_enterLeft_InLow  (cmp_l_n),
    .SC_ENTRYMANAGER_enterRight_InLow (cmp_r_n),
    .SC_ENTRYMANAGER_entryBUS_Out     (bus),
    .SC_ENTRYMANAGER_goalRow_Out      (goal),
    .SC_ENTRYMANAGER_filled_Out       (filled),
    .SC_ENTRYMANAGER_respawn_OutLow   (resp_n),
    .SC_ENTRYMANAGER_lose_OutLow      (lose_n),
    .SC_ENTRYMANAGER_win_OutLow       (win_n)
  );

  // Entry comparator: inactive on a zero bus, otherwise wall hit beats slot.
  always_comb begin
    cmp_lose_n = 1'b1;
    cmp_l_n    = 1'b1;
    cmp_r_n    = 1'b1;
    if (bus != 8'h00) begin
      if ((frog_pos & bus) != 8'h00) cmp_lose_n = 1'b0;
      else if (frog_pos[5])          cmp_l_n    = 1'b0;
      else if (frog_pos[2])          cmp_r_n    = 1'b0;
    end
  end

  // Behavioural model: modes idle / armed / playing a pulse script / waiting
  // for the frog to leave. Pulse frames are {respawn_n, lose_n, win_n}.
  localparam int M_IDLE = 0, M_ARM = 1, M_SCRIPT = 2, M_RELEASE = 3;
  int         m_mode;
  logic [7:0] m_pat;
  int         m_filled;
  logic       m_reload;
  logic [2:0] m_q[$];
  logic [7:0] e_bus;
  logic [2:0] e_pulse;

  task automatic m_reset();
    m_mode = M_IDLE; m_pat = BASE; m_filled = 0; m_reload = 1'b0;
    m_q.delete(); e_bus = 8'h00; e_pulse = 3'b111;
  endtask

  task automatic m_fill(input int bitpos);
    m_pat[bitpos] = 1'b1;
    m_filled++;
    m_q.push_back(3'b011);
    if (m_filled == 2) begin
      m_q.push_back(3'b110);
      m_reload = 1'b1;
    end
    m_mode = M_SCRIPT;
  endtask

  task automatic m_step();
    if (!clr_n) begin
      m_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (!at_top_n) m_mode = M_ARM;
      M_ARM: begin
        if (at_top_n) m_mode = M_IDLE;
        else if ((frog_pos & m_pat) != 8'h00) begin
          m_q.push_back(3'b001);
          m_mode = M_SCRIPT;
        end
        else if (frog_pos == POS_L) m_fill(5);
        else if (frog_pos == POS_R) m_fill(2);
      end
      M_SCRIPT: if (m_q.size() == 0) begin
        m_mode = M_RELEASE;
        if (m_reload) begin
          m_pat = BASE; m_filled = 0; m_reload = 1'b0;
        end
      end
      default: if (at_top_n) m_mode = M_IDLE;
    endcase
    e_pulse = (m_mode == M_SCRIPT) ? m_q.pop_front() : 3'b111;
    e_bus   = (m_mode == M_ARM) ? m_pat : 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("entry_bus", 32'(bus), 32'(e_bus));
    chk("goal_row", 32'(goal), 32'(m_pat));
    chk("filled", 32'(filled), 32'(m_filled));
    chk("respawn_n", 32'(resp_n), 32'(e_pulse[2]));
    chk("lose_n", 32'(lose_n), 32'(e_pulse[1]));
    chk("win_n", 32'(win_n), 32'(e_pulse[0]));
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1 ns later.
  task automatic cycle(input logic top_n, input logic [7:0] pos, input logic c_n);
    @(negedge clk);
    at_top_n = top_n; frog_pos = pos; clr_n = c_n;
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
  endtask

  logic [7:0] pos_tab [9];

  initial begin
    pos_tab = '{8'h20, 8'h04, 8'h01, 8'h02, 8'h08, 8'h10, 8'h40, 8'h80, 8'h00};

    #1 rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", 32'(bus), 32'h00);
    chk("rst_goal", 32'(goal), 32'hDB);
    chk("rst_pulses", 32'({resp_n, lose_n, win_n, filled}), 32'b11100);
    rst_n = 1'b1;

    cycle(1'b1, 8'h00, 1'b1);
    chk("idle_bus", 32'(bus), 32'h00);
    $display("[TB] reset/idle done");

    // Wall hit at a fresh level
    cycle(1'b0, 8'h08, 1'b1);
    chk("wall_arm_bus", 32'(bus), 32'hDB);
    cycle(1'b0, 8'h08, 1'b1);
    chk("wall_pulse", 32'({resp_n, lose_n, win_n}), 32'b001);
    chk("wall_goal", 32'(goal), 32'hDB);
    cycle(1'b0, 8'h08, 1'b1);
    chk("wall_pulse_end", 32'({resp_n, lose_n}), 32'b11);
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] lose on wall done");

    // Left entry
    cycle(1'b0, POS_L, 1'b1);
    chk("left_arm_bus", 32'(bus), 32'hDB);
    cycle(1'b0, POS_L, 1'b1);
    chk("left_respawn", 32'({resp_n, lose_n, win_n}), 32'b011);
    chk("left_goal", 32'(goal), 32'hFB);
    chk("left_filled", 32'(filled), 32'd1);
    cycle(1'b0, POS_L, 1'b1);
    cycle(1'b0, POS_L, 1'b1);
    chk("left_release_bus", 32'(bus), 32'h00);
    chk("left_release_resp", 32'(resp_n), 32'd1);
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] left entry done");

    // Re-entering a filled slot is a lose
    cycle(1'b0, POS_L, 1'b1);
    cycle(1'b0, POS_L, 1'b1);
    chk("refill_lose", 32'(lose_n), 32'd0);
    chk("refill_filled", 32'(filled), 32'd1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] filled-slot lose done");

    // Right entry completes the level
    cycle(1'b0, POS_R, 1'b1);
    chk("right_arm_bus", 32'(bus), 32'hFB);
    cycle(1'b0, POS_R, 1'b1);
    chk("right_fill", 32'({resp_n, win_n, filled}), 32'b0110);
    chk("right_goal", 32'(goal), 32'hFF);
    cycle(1'b0, POS_R, 1'b1);
    chk("win_pulse", 32'({resp_n, lose_n, win_n}), 32'b110);
    cycle(1'b0, POS_R, 1'b1);
    chk("win_reload", 32'({goal, 4'(filled), 4'(win_n)}), 32'hDB01);
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] win done");

    // Clear beats a fill decision
    cycle(1'b0, POS_R, 1'b1);
    cycle(1'b0, POS_R, 1'b0);
    chk("clr_no_pulse", 32'({resp_n, lose_n, win_n}), 32'b111);
    chk("clr_goal", 32'({goal, bus}), 32'hDB00);
    chk("clr_filled", 32'(filled), 32'd0);
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] clear priority done");

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      logic       t_n, c_n;
      logic [7:0] p;
      t_n = ($urandom_range(0, 3) == 0) ? ~at_top_n : at_top_n;
      p   = ($urandom_range(0, 2) == 0) ? pos_tab[$urandom_range(0, 8)] : frog_pos;
      c_n = ($urandom_range(0, 39) != 0);
      cycle(t_n, p, c_n);
    end
    $display("[TB] random play done");

    // Async reset in the middle of a lose pulse
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b0, 8'h01, 1'b1);
    cycle(1'b0, 8'h01, 1'b1);
    chk("pre_rst_lose", 32'(lose_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pulses", 32'({resp_n, lose_n, win_n}), 32'b111);
    chk("async_rst_bus", 32'(bus), 32'h00);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h00, 1'b1);
    $display("[TB] async reset mid-pulse done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_entry_manager.md
Name: sc_entry_manager

Overview:
- Owns the goal-row (entry) state of the Frogger board and drives the 8-bit entry bus into the entry comparator.
- Consumes the comparator's active-low lose / enterLeft / enterRight verdicts.
- Marks filled home slots, requests frog respawn, signals level win.
- Sits between the frog position logic (which flags "frog in goal row") and the comparator/matrix display path.

Parameters:
- DATAWIDTH, 8, width of the entry and pattern buses.
- BASE_PATTERN, 8'b11011011, goal-row wall pattern at level start (1 = wall, 0 = open slot).
- LEFT_BIT, 5, column index of the left home slot.
- RIGHT_BIT, 2, column index of the right home slot.

Ports:
- SC_ENTRYMANAGER_CLOCK_50  in  1  system clock.
- SC_ENTRYMANAGER_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_ENTRYMANAGER_clear_InLow  in  1  synchronous new-game clear, active-low.
- SC_ENTRYMANAGER_frogAtTop_InLow  in  1  low while frog occupies goal row.
- SC_ENTRYMANAGER_lose_InLow  in  1  comparator lose verdict.
- SC_ENTRYMANAGER_enterLeft_InLow  in  1  comparator left-slot verdict.
- SC_ENTRYMANAGER_enterRight_InLow  in  1  comparator right-slot verdict.
- SC_ENTRYMANAGER_entryBUS_Out  out  DATAWIDTH  entry bus to comparator; 0 = comparator inactive.
- SC_ENTRYMANAGER_goalRow_Out  out  DATAWIDTH  current pattern register, for display.
- SC_ENTRYMANAGER_filled_Out  out  2  number of filled slots, 0..2.
- SC_ENTRYMANAGER_respawn_OutLow  out  1  one-cycle pulse requesting frog respawn.
- SC_ENTRYMANAGER_lose_OutLow  out  1  one-cycle pulse, life lost.
- SC_ENTRYMANAGER_win_OutLow  out  1  one-cycle pulse, level complete.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - pattern = BASE_PATTERN
  - filled = 0
  - entryBUS_Out = 0
  - all _OutLow outputs = 1
- Output registration: all outputs are registered. entryBUS_Out = pattern in state ARM, 0 in every other state.
- State IDLE:
  - If frogAtTop_InLow = 0, go to ARM next cycle.
- State ARM:
  - Comparator inputs are combinational from the registered entryBUS_Out and are sampled at the end of the ARM cycle.
  - Priority of decisions:
    1. If frogAtTop_InLow = 1, go to IDLE (frog left the row).
    2. Else if lose_InLow = 0, go to LOSE.
    3. Else if enterLeft_InLow = 0 and pattern[LEFT_BIT] = 0, go to FILL_L.
    4. Else if enterRight_InLow = 0 and pattern[RIGHT_BIT] = 0, go to FILL_R.
    5. Else stay in ARM.
  - An already-filled slot is a wall, so the comparator reports lose; lose priority covers that case.
- State LOSE:
  - Assert lose_OutLow = 0 and respawn_OutLow = 0 for exactly 1 cycle.
  - Go to RELEASE.
- States FILL_L / FILL_R:
  - Set pattern[LEFT_BIT] or pattern[RIGHT_BIT], increment filled, pulse respawn_OutLow for 1 cycle.
  - If filled becomes 2, go to WIN; else go to RELEASE.
- State WIN:
  - Pulse win_OutLow for 1 cycle.
  - Reload pattern = BASE_PATTERN and filled = 0.
  - Go to RELEASE.
- State RELEASE:
  - Hold entryBUS_Out = 0 until frogAtTop_InLow = 1, then go to IDLE.
  - This prevents double scoring while the frog is still in the goal row.
- Latency: frogAtTop asserted to entry bus driven is 1 cycle; verdict to output pulse is 1 cycle.
- clear_InLow = 0:
  - Has priority over every transition and every pending fill.
  - Next state is IDLE with pattern = BASE_PATTERN, filled = 0, and no pulses.
- filled saturates at 2; it never wraps. Pulses never overlap, except that respawn coincides with lose or fill.
- Reset mid-operation (including during a pulse) immediately returns all outputs to their reset values.

Decomposition:
- Shared package (frogger_pkg) holds:
  - state encoding (IDLE, ARM, LOSE, FILL_L, FILL_R, WIN, RELEASE; 3-bit)
  - BASE_PATTERN
  - LEFT_BIT / RIGHT_BIT
  - the DATAWIDTH default
- No sub-module. The FSM plus the pattern/filled registers live in one file, split into a combinational next-state block and a sequential register block.

Test Plan:
- Reset then idle:
  - Release reset with frogAtTop_InLow = 1 -> entryBUS_Out = 0x00, goalRow_Out = 0xDB, filled = 0, all pulses high.
- Left entry:
  - frogAtTop_InLow = 0, with a comparator model given frog = 0x20.
  - Expected: entryBUS_Out = 0xDB one cycle later, then one respawn pulse, pattern = 0xFB, filled = 1.
  - entryBUS_Out stays 0 until frogAtTop_InLow returns high.
- Lose on wall:
  - Frog = 0x08 in goal row -> lose_OutLow and respawn_OutLow low for exactly 1 cycle; pattern unchanged at 0xDB.
- Filled slot counts as lose:
  - After left fill, enter again with frog = 0x20 -> lose pulse; filled stays 1.
- Win:
  - Fill left, then right (frog = 0x04) -> filled reaches 2, win_OutLow pulses 1 cycle after the fill cycle.
  - Afterwards pattern reloads to 0xDB and filled = 0.
- Clear and reset priority:
  - clear_InLow = 0 in the same cycle as an ARM->FILL_R decision -> no fill, no pulse, state IDLE, pattern 0xDB.
  - RESET_InLow = 0 during a lose pulse -> the pulse ends asynchronously.
